mhd_monitor_ctrl: RTL and testbench

- Sequential controller that runs a Hamming-distance error-monitoring session over a stream of word pairs, typically exact versus approximate circuit outputs.
- Accepts pairs over a valid/ready handshake and computes per-pair Hamming distance in a 2-stage pipeline.
- Flags pairs whose distance exceeds a programmable threshold and accumulates session statistics: violation count, maximum distance, and index of the first violation.
- Sits between the stimulus source and the result/report logic of the approximate-circuit evaluation flow.

---
 rtl/mhd_pkg.sv | 20 ++
 rtl/mhd_monitor_ctrl_if.sv | 45 ++++
 rtl/mhd_popcount.sv | 21 ++
 rtl/mhd_monitor_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mhd_monitor_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mhd_pkg.sv
// Shared definitions for the Hamming-distance monitor: default sizes, FSM
// state encoding and the distance-width helper used by every block.
package mhd_pkg;

   localparam int unsigned MHD_WIDTH = 16;
   localparam int unsigned MHD_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } mhd_state_e;

   // Bits needed to hold a distance in 0..w.
   function automatic int unsigned hd_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/mhd_monitor_ctrl_if.sv
// Bus bundle for mhd_monitor_ctrl.
//   master (stimulus/report side) drives: start, n_samples, thr, stop_on_err,
//     in_valid, a, b
//   slave (controller) drives: in_ready, hd_valid, hd_out, hd_viol, busy,
//     done, err_cnt, max_hd, first_err_vld, first_err_idx
interface mhd_monitor_ctrl_if
   import mhd_pkg::*;
#(
   parameter int unsigned WIDTH = MHD_WIDTH,
   parameter int unsigned CNT_W = MHD_CNT_W
) ();

   localparam int unsigned HD_W = hd_width(WIDTH);

   logic             start;
   logic [CNT_W-1:0] n_samples;
   logic [HD_W-1:0]  thr;
   logic             stop_on_err;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hd_valid;
   logic [HD_W-1:0]  hd_out;
   logic             hd_viol;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] err_cnt;
   logic [HD_W-1:0]  max_hd;
   logic             first_err_vld;
   logic [CNT_W-1:0] first_err_idx;

   modport master (
      output start, n_samples, thr, stop_on_err, in_valid, a, b,
      input  in_ready, hd_valid, hd_out, hd_viol, busy, done,
             err_cnt, max_hd, first_err_vld, first_err_idx
   );

   modport slave (
      input  start, n_samples, thr, stop_on_err, in_valid, a, b,
      output in_ready, hd_valid, hd_out, hd_viol, busy, done,
             err_cnt, max_hd, first_err_vld, first_err_idx
   );

endinterface

// File: rtl/mhd_popcount.sv
// Combinational population count of a WIDTH-bit word.
//   din     : word to count
//   count_c : number of set bits (0..WIDTH)
module mhd_popcount
   import mhd_pkg::*;
#(
   parameter int unsigned WIDTH = MHD_WIDTH,
   parameter int unsigned HD_W  = hd_width(WIDTH)
) (
   input  logic [WIDTH-1:0] din,
   output logic [HD_W-1:0]  count_c
);

   always_comb begin
      count_c = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         count_c = count_c + HD_W'(din[i]);
      end
   end

endmodule

// File: rtl/mhd_monitor_ctrl.sv
// Hamming-distance monitoring session controller.
//   clk, rst_n : clock (rising edge), async active-low reset
//   bus        : slave side of mhd_monitor_ctrl_if
//     session control in : start, n_samples, thr, stop_on_err
//     pair stream in     : in_valid/in_ready handshake, a, b
//     per-pair out       : hd_valid, hd_out, hd_viol (two cycles after transfer)
//     session out        : busy, done, err_cnt, max_hd, first_err_vld,
//                          first_err_idx
module mhd_monitor_ctrl
   import mhd_pkg::*;
#(
   parameter int unsigned WIDTH = MHD_WIDTH,
   parameter int unsigned CNT_W = MHD_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   mhd_monitor_ctrl_if.slave bus
);

   localparam int unsigned HD_W = hd_width(WIDTH);

   localparam logic [1:0] S_IDLE  = 2'(IDLE);
   localparam logic [1:0] S_RUN   = 2'(RUN);
   localparam logic [1:0] S_DRAIN = 2'(DRAIN);
   localparam logic [1:0] S_DONE  = 2'(DONE);

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] n_lat, n_nxt;
   logic [CNT_W-1:0] acc_cnt, acc_nxt;
   logic [HD_W-1:0]  thr_lat, thr_nxt;
   logic             stop_lat, stop_lat_nxt;
   logic             stop_flag, stop_flag_nxt;
   logic [CNT_W-1:0] err_cnt, err_nxt;
   logic [HD_W-1:0]  max_hd, max_nxt;
   logic             first_vld, first_vld_nxt;
   logic [CNT_W-1:0] first_idx, first_idx_nxt;
   logic             in_ready, busy, done;
   logic             xfer_c;

   logic             s1_vld;
   logic [WIDTH-1:0] s1_diff;
   logic [CNT_W-1:0] s1_idx;
   logic             s2_vld;
   logic [HD_W-1:0]  s2_hd;
   logic             s2_viol;
   logic [CNT_W-1:0] s2_idx;
   logic [HD_W-1:0]  pop_c;

   // in_ready is only ever high in RUN, so this alone qualifies a transfer.
   assign xfer_c = bus.in_valid & in_ready;

   mhd_popcount #(.WIDTH(WIDTH), .HD_W(HD_W)) u_popcount (
      .din     (s1_diff),
      .count_c (pop_c)
   );

   // Next-state and session statistics.
   always_comb begin
      state_nxt     = state;
      n_nxt         = n_lat;
      acc_nxt       = acc_cnt;
      thr_nxt       = thr_lat;
      stop_lat_nxt  = stop_lat;
      stop_flag_nxt = stop_flag;
      err_nxt       = err_cnt;
      max_nxt       = max_hd;
      first_vld_nxt = first_vld;
      first_idx_nxt = first_idx;

      // Stats follow the pipeline output; in-flight pairs keep counting in DRAIN.
      if (s2_vld) begin
         if (s2_hd > max_hd) max_nxt = s2_hd;
         if (s2_viol) begin
            if (err_cnt != '1) err_nxt = err_cnt + CNT_W'(1);
            if (!first_vld) begin
               first_vld_nxt = 1'b1;
               first_idx_nxt = s2_idx;
            end
            if (stop_lat) stop_flag_nxt = 1'b1;
         end
      end

      if (xfer_c) acc_nxt = acc_cnt + CNT_W'(1);

      case (state)
         S_IDLE: begin
            if (bus.start) begin
               n_nxt         = bus.n_samples;
               thr_nxt       = bus.thr;
               stop_lat_nxt  = bus.stop_on_err;
               stop_flag_nxt = 1'b0;
               acc_nxt       = '0;
               err_nxt       = '0;
               max_nxt       = '0;
               first_vld_nxt = 1'b0;
               first_idx_nxt = '0;
               state_nxt     = (bus.n_samples == '0) ? S_DRAIN : S_RUN;
            end
         end
         S_RUN: begin
            // Final transfer and stop can coincide; the transfer still counts.
            if ((acc_nxt == n_lat) || stop_flag_nxt) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (!s1_vld && !s2_vld) state_nxt = S_DONE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State, latched parameters, statistics and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         n_lat     <= '0;
         acc_cnt   <= '0;
         thr_lat   <= '0;
         stop_lat  <= 1'b0;
         stop_flag <= 1'b0;
         err_cnt   <= '0;
         max_hd    <= '0;
         first_vld <= 1'b0;
         first_idx <= '0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         n_lat     <= n_nxt;
         acc_cnt   <= acc_nxt;
         thr_lat   <= thr_nxt;
         stop_lat  <= stop_lat_nxt;
         stop_flag <= stop_flag_nxt;
         err_cnt   <= err_nxt;
         max_hd    <= max_nxt;
         first_vld <= first_vld_nxt;
         first_idx <= first_idx_nxt;
         // RUN is only entered or kept while acc_cnt < n_lat and no stop is pending.
         in_ready  <= (state_nxt == S_RUN);
         busy      <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
         done      <= (state_nxt == S_DONE);
      end
   end

   // Two-stage distance pipeline: XOR, then popcount and threshold compare.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld  <= 1'b0;
         s1_diff <= '0;
         s1_idx  <= '0;
         s2_vld  <= 1'b0;
         s2_hd   <= '0;
         s2_viol <= 1'b0;
         s2_idx  <= '0;
      end else begin
         s1_vld <= xfer_c;
         if (xfer_c) begin
            s1_diff <= bus.a ^ bus.b;
            s1_idx  <= acc_cnt;
         end
         s2_vld  <= s1_vld;
         s2_viol <= s1_vld && (pop_c > thr_lat);
         if (s1_vld) begin
            s2_hd  <= pop_c;
            s2_idx <= s1_idx;
         end
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.hd_valid      = s2_vld;
   assign bus.hd_out        = s2_hd;
   assign bus.hd_viol       = s2_viol;
   assign bus.busy          = busy;
   assign bus.done          = done;
   assign bus.err_cnt       = err_cnt;
   assign bus.max_hd        = max_hd;
   assign bus.first_err_vld = first_vld;
   assign bus.first_err_idx = first_idx;

endmodule

// File: tb/tb_mhd_monitor_ctrl.sv
// Randomized self-checking bench for mhd_monitor_ctrl with a session-level
// reference model driven by edge arithmetic over the transfer timeline.
module tb_mhd_monitor_ctrl;
   import mhd_pkg::*;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned CNT4  = 4;
   localparam int unsigned HD_W  = hd_width(WIDTH);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mhd_monitor_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus  ();
   mhd_monitor_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT4))  bus4 ();

   mhd_monitor_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
   mhd_monitor_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int cyc; int hd; bit viol; } hd_exp_t;
   typedef struct { logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; } pair_t;
   hd_exp_t hdq[$];
   pair_t   pq[$];

   bit sess_active = 0;
   bit exp_ready   = 0;
   int idle_edge   = 0;
   int s_edge, n_m, thr_m, acc_m, nviol_m, max_m, fidx_m;
   bit stop_m, fvld_m;
   int vk_edge, last_t, end_edge, done_edge;
   int hdv_seen;

   // Session bookkeeping at a rising edge, using what the bench drove before it.
   task automatic model_edge();
      int e;
      int hd;
      bit v;
      e = cyc;
      if (sess_active && done_edge >= 0 && e == done_edge + 1) begin
         sess_active = 0;
         idle_edge   = e;
      end
      if (sess_active && bus.in_valid && exp_ready) begin
         hd = $countones(bus.a ^ bus.b);
         v  = (hd > thr_m);
         hdq.push_back('{e + 1, hd, v});
         if (hd > max_m) max_m = hd;
         if (v) begin
            nviol_m++;
            if (!fvld_m) begin fvld_m = 1; fidx_m = acc_m; end
            if (vk_edge < 0) vk_edge = e;
         end
         acc_m++;
         last_t = e;
         void'(pq.pop_front());
      end
      if (sess_active && end_edge < 0) begin
         if (acc_m == n_m) end_edge = e;
         else if (stop_m && vk_edge >= 0 && e == vk_edge + 2) end_edge = e;
         if (end_edge >= 0) done_edge = ((e > last_t + 2) ? e : last_t + 2) + 1;
      end
      if (!sess_active && bus.start && e > idle_edge) begin
         sess_active = 1;
         s_edge  = e;
         n_m     = int'(bus.n_samples);
         thr_m   = int'(bus.thr);
         stop_m  = bus.stop_on_err;
         acc_m   = 0; nviol_m = 0; max_m = 0; fidx_m = 0; fvld_m = 0;
         vk_edge = -1; last_t = -1; end_edge = -1; done_edge = -1;
         if (n_m == 0) begin end_edge = e; done_edge = e + 1; end
      end
   endtask

   // Compare every DUT output against the model for the current cycle.
   task automatic check_cycle();
      bit exp_hdv, exp_busy, exp_done;
      exp_hdv  = (hdq.size() > 0) && (hdq[0].cyc == cyc);
      exp_ready = sess_active && (end_edge < 0);
      exp_busy = sess_active && (done_edge < 0 || cyc < done_edge);
      exp_done = sess_active && (cyc == done_edge);
      if (bus.hd_valid === 1'b1) hdv_seen++;
      check("in_ready", bus.in_ready, exp_ready);
      check("busy", bus.busy, exp_busy);
      check("done", bus.done, exp_done);
      check("hd_valid", bus.hd_valid, exp_hdv);
      if (exp_hdv) begin
         check("hd_out", bus.hd_out, hdq[0].hd);
         check("hd_viol", bus.hd_viol, hdq[0].viol);
         void'(hdq.pop_front());
      end
      if (exp_done) begin
         check("err_cnt", bus.err_cnt, (nviol_m > 65535) ? 65535 : nviol_m);
         check("max_hd", bus.max_hd, max_m);
         check("first_err_vld", bus.first_err_vld, fvld_m);
         check("first_err_idx", bus.first_err_idx, fidx_m);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_edge();
      @(negedge clk);
      check_cycle();
   endtask

   // ---------------- stimulus ----------------
   function automatic pair_t rand_pair();
      pair_t p;
      logic [WIDTH-1:0] m;
      p.a = WIDTH'($urandom);
      case ($urandom_range(3))
         0: m = WIDTH'(1) << $urandom_range(WIDTH - 1);
         1: m = WIDTH'($urandom) & WIDTH'($urandom) & WIDTH'($urandom);
         2: m = WIDTH'($urandom);
         default: m = ($urandom_range(1) != 0) ? '1 : '0;
      endcase
      p.b = p.a ^ m;
      return p;
   endfunction

   task automatic push_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      pair_t p;
      p.a = a;
      p.b = b;
      pq.push_back(p);
   endtask

   task automatic drive_cycle(input int pct);
      bus.start    = 1'b0;
      bus.in_valid = ($urandom_range(99) < pct);
      if (bus.in_valid) begin
         if (pq.size() == 0) pq.push_back(rand_pair());
         bus.a = pq[0].a;
         bus.b = pq[0].b;
      end else begin
         bus.a = WIDTH'($urandom);
         bus.b = WIDTH'($urandom);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_in_ready"}, bus.in_ready, 0);
      check({tag, "_hd_valid"}, bus.hd_valid, 0);
      check({tag, "_hd_out"}, bus.hd_out, 0);
      check({tag, "_hd_viol"}, bus.hd_viol, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_err_cnt"}, bus.err_cnt, 0);
      check({tag, "_max_hd"}, bus.max_hd, 0);
      check({tag, "_first_vld"}, bus.first_err_vld, 0);
      check({tag, "_first_idx"}, bus.first_err_idx, 0);
      check({tag, "_busy4"}, bus4.busy, 0);
      check({tag, "_err_cnt4"}, bus4.err_cnt, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check_zero("reset");
      sess_active = 0;
      exp_ready = 0;
      hdq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle_edge = cyc;
   endtask

   // One session; poke = iteration for an ignored start, abort = iteration for reset.
   task automatic run_session(input int n, input int th, input bit st, input int pct,
                              input int poke, input int abort);
      int it;
      bit aborted;
      bus.start       = 1'b1;
      bus.n_samples   = CNT_W'(n);
      bus.thr         = HD_W'(th);
      bus.stop_on_err = st;
      bus.in_valid    = 1'b0;
      hdv_seen        = 0;
      tick();
      bus.start = 1'b0;
      it = 0;
      aborted = 0;
      while (sess_active && it < 400) begin
         if (it == abort) begin
            do_reset();
            aborted = 1;
            break;
         end
         drive_cycle(pct);
         if (it == poke) begin
            bus.start       = 1'b1;
            bus.n_samples   = CNT_W'(n + 5);
            bus.thr         = HD_W'((th + 7) % 17);
            bus.stop_on_err = !st;
         end
         tick();
         it++;
      end
      bus.start = 1'b0;
      if (!aborted) check("session_timeout", sess_active, 0);
      bus.in_valid = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      int k, h4;
      rst_n = 1'b0;
      bus.start = 0; bus.n_samples = '0; bus.thr = '0; bus.stop_on_err = 0;
      bus.in_valid = 0; bus.a = '0; bus.b = '0;
      bus4.start = 0; bus4.n_samples = '0; bus4.thr = '0; bus4.stop_on_err = 0;
      bus4.in_valid = 0; bus4.a = '0; bus4.b = '0;
      repeat (3) @(negedge clk);
      check_zero("init");
      rst_n = 1'b1;
      idle_edge = cyc;

      // Basic session from the reference table.
      pq.delete();
      push_pair(16'h0000, 16'h0001);
      push_pair(16'h0000, 16'h0007);
      push_pair(16'h0000, 16'hFFFF);
      push_pair(16'h0000, 16'h0003);
      run_session(4, 2, 0, 100, -1, -1);
      check("tp1_err_cnt", bus.err_cnt, 2);
      check("tp1_max_hd", bus.max_hd, 16);
      check("tp1_first_idx", bus.first_err_idx, 1);
      check("tp1_first_vld", bus.first_err_vld, 1);

      // Full throughput.
      run_session(8, 8, 0, 100, -1, -1);
      check("thru_hdv_count", hdv_seen, 8);

      // Stop on first error with two pairs in flight.
      pq.delete();
      for (int i = 0; i < 10; i++) begin
         k = 16'h1357 * (i + 1);
         push_pair(WIDTH'(k), (i == 2) ? WIDTH'(k) ^ 16'h0010 : WIDTH'(k));
      end
      run_session(10, 0, 1, 100, -1, -1);
      check("stop_err_cnt", bus.err_cnt, 1);
      check("stop_first_idx", bus.first_err_idx, 2);
      check("stop_pairs", hdv_seen, 5);

      // Empty session.
      run_session(0, 3, 0, 100, -1, -1);
      check("n0_err_cnt", bus.err_cnt, 0);
      check("n0_max_hd", bus.max_hd, 0);
      check("n0_first_vld", bus.first_err_vld, 0);

      // thr = WIDTH never violates; start during RUN is ignored.
      pq.delete();
      for (int i = 0; i < 6; i++) begin
         k = int'($urandom);
         push_pair(WIDTH'(k), ~WIDTH'(k));
      end
      run_session(6, 16, 1, 100, 2, -1);
      check("thr16_err_cnt", bus.err_cnt, 0);
      check("thr16_max_hd", bus.max_hd, 16);
      check("thr16_pairs", hdv_seen, 6);

      // Reset mid-RUN, then a normal session.
      run_session(10, 3, 0, 80, -1, 4);
      run_session(5, 4, 0, 70, -1, -1);

      // Randomized sessions.
      for (int s = 0; s < 25; s++) begin
         run_session($urandom_range(12), $urandom_range(16), 1'($urandom_range(1)),
                     $urandom_range(40, 100), ($urandom_range(3) == 0) ? 3 : -1, -1);
      end

      // Narrow counters: every one of the 15 pairs violates.
      bus4.start = 1; bus4.n_samples = 4'd15; bus4.thr = '0; bus4.stop_on_err = 0;
      bus4.in_valid = 1; bus4.a = 16'h0000; bus4.b = 16'h0001;
      tick();
      bus4.start = 0;
      k = 0; h4 = 0;
      while (bus4.done !== 1'b1 && k < 80) begin
         tick();
         k++;
         if (bus4.hd_valid === 1'b1) h4++;
      end
      bus4.in_valid = 0;
      check("sat_done", bus4.done, 1);
      check("sat_err_cnt", bus4.err_cnt, 15);
      check("sat_max_hd", bus4.max_hd, 1);
      check("sat_first_idx", bus4.first_err_idx, 0);
      check("sat_pairs", h4, 15);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
